// File: rtl/signed_mul_seq_pkg.sv
// signed_mul_seq_pkg
// Shared definitions for the sequential signed/unsigned multiplier:
//   - DefaultWidth    : default operand width
//   - cnt_width()     : iteration counter width for a given operand width
//   - DefaultCntWidth : counter width for the default operand width
//   - state_e         : controller state encoding
package signed_mul_seq_pkg;

    localparam int unsigned DefaultWidth = 32;

    // Counter must index iterations 0..w-1; keep at least one bit.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int unsigned DefaultCntWidth = cnt_width(DefaultWidth);

    typedef enum logic [2:0] {
        StIdle,
        StPrep,
        StCalc,
        StFix,
        StDone
    } state_e;

endpackage

// File: rtl/cond_negate.sv
// cond_negate
// Combinational conditional two's-complement negation.
// Ports:
//   in  [W-1:0] : value
//   neg         : 1 = output -in, 0 = pass through
//   out [W-1:0] : result
module cond_negate #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] in,
    input  logic         neg,
    output logic [W-1:0] out
);

    assign out = neg ? (~in + W'(1)) : in;

endmodule

// File: rtl/signed_mul_seq.sv
// signed_mul_seq
// Sequential multiplier: sign/magnitude conversion, WIDTH shift-add iterations, sign fix.
// An accepted request produces done_o in the cycle after edge N+WIDTH+2.
// Ports:
//   clk_i    : clock, rising edge
//   rst_i    : synchronous active-high reset
//   start_i  : request, accepted only while ready_o=1
//   signed_i : 1 = two's-complement operands, 0 = unsigned (sampled with start_i)
//   src1_i   : multiplicand (sampled with start_i)
//   src2_i   : multiplier (sampled with start_i)
//   ready_o  : idle, can accept a request
//   busy_o   : operation in progress
//   done_o   : single-cycle completion pulse
//   result_o : registered 2*WIDTH product, held until the next completion
// WIDTH must be at least 2.
module signed_mul_seq
    import signed_mul_seq_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               signed_i,
    input  logic [WIDTH-1:0]   src1_i,
    input  logic [WIDTH-1:0]   src2_i,
    output logic               ready_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [2*WIDTH-1:0] result_o
);

    localparam int unsigned CntW = cnt_width(WIDTH);
    localparam logic [CntW-1:0] LastIter = CntW'(WIDTH - 1);

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     src1_q, src2_q;
    logic                 signed_q, sign_q;
    logic [CntW-1:0]      cnt_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [2*WIDTH-1:0]   result_q;

    logic [WIDTH-1:0]     mag1, mag2;
    logic [2*WIDTH-1:0]   acc_fix;
    logic [WIDTH:0]       step_sum;

    cond_negate #(.W(WIDTH)) u_mag1 (
        .in  (src1_q),
        .neg (signed_q & src1_q[WIDTH-1]),
        .out (mag1)
    );

    cond_negate #(.W(WIDTH)) u_mag2 (
        .in  (src2_q),
        .neg (signed_q & src2_q[WIDTH-1]),
        .out (mag2)
    );

    cond_negate #(.W(2*WIDTH)) u_fix (
        .in  (acc_q),
        .neg (sign_q),
        .out (acc_fix)
    );

    // Accumulator is {partial_hi, remaining_multiplier_bits}; each step adds the
    // multiplicand into the upper half when the current LSB is set, then shifts
    // right. The extra carry bit of step_sum shifts into the top.
    assign step_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, src1_q} : '0);

    always_comb begin
        state_d = state_q;
        ready_o = 1'b0;
        busy_o  = 1'b0;
        done_o  = 1'b0;
        unique case (state_q)
            StIdle: begin
                ready_o = 1'b1;
                if (start_i) state_d = StPrep;
            end
            StPrep: begin
                busy_o  = 1'b1;
                state_d = StCalc;
            end
            StCalc: begin
                busy_o = 1'b1;
                if (cnt_q == LastIter) state_d = StFix;
            end
            StFix: begin
                busy_o  = 1'b1;
                state_d = StDone;
            end
            StDone: begin
                done_o  = 1'b1;
                state_d = StIdle;
            end
            default: begin
                ready_o = 1'b1;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            src1_q   <= '0;
            src2_q   <= '0;
            signed_q <= 1'b0;
            sign_q   <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        src1_q   <= src1_i;
                        src2_q   <= src2_i;
                        signed_q <= signed_i;
                    end
                end
                StPrep: begin
                    src1_q <= mag1;
                    acc_q  <= {{WIDTH{1'b0}}, mag2};
                    sign_q <= signed_q & (src1_q[WIDTH-1] ^ src2_q[WIDTH-1]);
                    cnt_q  <= '0;
                end
                StCalc: begin
                    acc_q <= {step_sum, acc_q[WIDTH-1:1]};
                    cnt_q <= cnt_q + CntW'(1);
                end
                StFix: begin
                    acc_q    <= acc_fix;
                    result_q <= acc_fix;
                end
                default: ;
            endcase
        end
    end

    assign result_o = result_q;

endmodule

// File: tb/tb_signed_mul_seq.sv
// tb_signed_mul_seq
// Randomized and directed bench for signed_mul_seq (WIDTH=32) against a
// cycle-count/arithmetic reference model.
module tb_signed_mul_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sgn;
    logic [31:0] src1, src2;
    logic        ready, busy, done;
    logic [63:0] result;

    int n_tests = 0;
    int n_fail  = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    signed_mul_seq #(.WIDTH(32)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .start_i  (start),
        .signed_i (sgn),
        .src1_i   (src1),
        .src2_i   (src2),
        .ready_o  (ready),
        .busy_o   (busy),
        .done_o   (done),
        .result_o (result)
    );

    // Exact product from plain 64-bit arithmetic.
    function automatic logic [63:0] model_mul(input logic [31:0] a, input logic [31:0] b,
                                              input logic s);
        longint pa, pb;
        if (s) begin
            pa = longint'($signed(a));
            pb = longint'($signed(b));
        end else begin
            pa = longint'({32'b0, a});
            pb = longint'({32'b0, b});
        end
        return 64'(pa * pb);
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: m_age = cycles since the accepting edge, -1 when idle.
    int          m_age = -1;
    logic [31:0] m_a = '0, m_b = '0;
    logic        m_s = 1'b0;
    logic [63:0] m_res = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_age <= -1;
            m_res <= '0;
        end else if (m_age < 0) begin
            if (start) begin
                m_age <= 0;
                m_a   <= src1;
                m_b   <= src2;
                m_s   <= sgn;
            end
        end else if (m_age == 34) begin
            m_age <= -1;
        end else begin
            m_age <= m_age + 1;
            if (m_age == 33) m_res <= model_mul(m_a, m_b, m_s);
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            check("ready", {63'b0, ready}, {63'b0, m_age < 0});
            check("busy", {63'b0, busy}, {63'b0, (m_age >= 0) && (m_age <= 33)});
            check("done", {63'b0, done}, {63'b0, m_age == 34});
            check("result", result, m_res);
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("wait_ready", {63'b0, ready}, 64'd1);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [63:0] exp, input string name);
        int lat;
        wait_ready();
        @(negedge clk);
        start = 1'b1;
        sgn   = s;
        src1  = a;
        src2  = b;
        @(posedge clk);
        #1;
        // Scramble inputs while busy; they must not matter.
        start = 1'b0;
        src1  = $urandom;
        src2  = $urandom;
        sgn   = 1'($urandom_range(0, 1));
        lat   = 0;
        while (!done && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({name, "_latency"}, 64'(lat), 64'd34);
        check(name, result, exp);
        // Request during DONE must be dropped.
        start = 1'b1;
        @(posedge clk);
        #1;
        check({name, "_done_start_ignored"}, {63'b0, ready}, 64'd1);
        start = 1'b0;
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b;
        logic        s;

        rst   = 1'b1;
        start = 1'b0;
        sgn   = 1'b0;
        src1  = '0;
        src2  = '0;

        // Reset held two cycles.
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", {63'b0, ready}, 64'd1);
        check("rst_done", {63'b0, done}, 64'd0);
        check("rst_result", result, 64'd0);
        check_en = 1'b1;

        // Start while in reset has no effect.
        start = 1'b1;
        src1  = 32'd5;
        src2  = 32'd6;
        @(posedge clk);
        #1;
        check("rst_start_ready", {63'b0, ready}, 64'd1);
        check("rst_start_busy", {63'b0, busy}, 64'd0);
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b0;

        // Pin the model to hand-computed values.
        check("model_neg3x7", model_mul(32'hFFFF_FFFD, 32'd7, 1'b1), 64'hFFFF_FFFF_FFFF_FFEB);
        check("model_minxmin", model_mul(32'h8000_0000, 32'h8000_0000, 1'b1),
              64'h4000_0000_0000_0000);
        check("model_umax", model_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0),
              64'hFFFF_FFFE_0000_0001);

        // Directed cases with literal expectations.
        run_op(32'hFFFF_FFFD, 32'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB, "neg3x7");
        run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, "minxmin");
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, "umax");
        run_op(32'd0, 32'hFFFF_FFFB, 1'b1, 64'h0, "zeroxneg5");
        run_op(32'hFFFF_FFFF, 32'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, "neg1x1");
        run_op(32'h8000_0000, 32'd1, 1'b0, 64'h0000_0000_8000_0000, "umin_as_unsigned");

        // Reset mid-CALC: abort, no done pulse, result cleared.
        wait_ready();
        @(negedge clk);
        start = 1'b1;
        sgn   = 1'b1;
        src1  = 32'd1234;
        src2  = 32'hFFFF_0000;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_ready", {63'b0, ready}, 64'd1);
        check("abort_busy", {63'b0, busy}, 64'd0);
        check("abort_result", result, 64'd0);
        rst = 1'b0;
        run_op(32'd1000, 32'hFFFF_FFFE, 1'b1, 64'hFFFF_FFFF_FFFF_F830, "after_abort");

        // start held high with inputs changing every cycle.
        @(negedge clk);
        start = 1'b1;
        repeat (160) begin
            @(negedge clk);
            src1 = $urandom;
            src2 = $urandom;
            sgn  = 1'($urandom_range(0, 1));
        end
        start = 1'b0;

        // Randomized operations.
        for (int i = 0; i < 60; i++) begin
            a = pick_operand();
            b = pick_operand();
            s = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_op(a, b, s, model_mul(a, b, s), "random");
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/signed_mul_seq.md
SIGNED_MUL_SEQ -- requirements
Module: signed_mul_seq

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits; result width is 2*WIDTH.
REQ-002 The design SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk_i  input  1  sole clock, all state updates on rising edge.
REQ-004 rst_i  input  1  synchronous active-high reset.
REQ-005 start_i  input  1  request; accepted only while ready_o=1.
REQ-006 signed_i  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start_i.
REQ-007 src1_i  input  WIDTH  multiplicand; sampled with start_i.
REQ-008 src2_i  input  WIDTH  multiplier; sampled with start_i.
REQ-009 ready_o  output  1  high in IDLE only.
REQ-010 busy_o  output  1  high in PREP, CALC, FIX.
REQ-011 done_o  output  1  single-cycle pulse, high in DONE only.
REQ-012 result_o  output  2*WIDTH  registered product.

Function
REQ-013 FSM states SHALL be IDLE, PREP, CALC, FIX, DONE.
REQ-014 IDLE->PREP on an edge with start_i=1; operands and signed_i are latched on that edge (edge N). Later input changes have no effect.
REQ-015 PREP (1 cycle): if signed_i and an operand's MSB=1, replace it with its magnitude (invert all bits, add 1). Record sign = MSB1 XOR MSB2. If signed_i=0, sign=0 and operands pass unchanged.
REQ-016 CALC: WIDTH iterations, one per cycle, of shift-add on the 2*WIDTH accumulator; an iteration counter 0..WIDTH-1 is cleared on PREP->CALC.
REQ-017 CALC->FIX on the edge completing iteration WIDTH-1.
REQ-018 FIX (1 cycle): if sign=1, two's-complement negate the 2*WIDTH accumulator. Load result_o on the FIX->DONE edge.
REQ-019 done_o SHALL be high in the cycle after edge N+WIDTH+2 (N+34 for WIDTH=32). DONE->IDLE on the next edge, unconditionally.
REQ-020 start_i while not IDLE (including DONE) SHALL be ignored, with no queuing.
REQ-021 result_o SHALL hold its value until the next FIX->DONE edge.
REQ-022 Magnitude of -2^(WIDTH-1) SHALL be 2^(WIDTH-1) as an unsigned WIDTH-bit value. No overflow is possible; the full 2*WIDTH product is always exact.
REQ-023 Zero operand SHALL yield 0 with sign forced irrelevant: negating 0 gives 0.
REQ-024 ready_o, busy_o and done_o SHALL be mutually exclusive, and exactly one SHALL be high in every cycle.

Reset
REQ-025 rst_i=1 at an edge SHALL force IDLE, result_o=0, counter=0, accumulator=0, and clear latched operands and sign.
REQ-026 After reset: ready_o=1, busy_o=0, done_o=0.
REQ-027 Reset in any state, including mid-CALC, SHALL abort the operation with no done_o pulse. Reset has priority over start_i.

Structure
REQ-028 A shared package SHALL hold the FSM state enum, the default WIDTH, and the counter width $clog2(WIDTH).
REQ-029 One combinational sub-module, cond_negate (parameter W; inputs in[W-1:0] and neg; output out = neg ? ~in+1 : in), SHALL be instantiated three times: twice for operand magnitudes and once for the result fix.
REQ-030 All state SHALL be in a single clocked process. There are no latches and no asynchronous logic.

Verification
REQ-031 Reset then idle: rst_i held for 2 cycles -> ready_o=1, result_o=0, done_o=0. Apply start_i with rst_i=1 -> no state change.
REQ-032 Signed basic: src1=-3 (0xFFFFFFFD), src2=7, signed_i=1 -> done_o after edge N+34, result_o=0xFFFFFFFF_FFFFFFEB (-21).
REQ-033 Extremes: signed -2^31 x -2^31 -> 0x40000000_00000000. Unsigned 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE_00000001.
REQ-034 Zero and sign: signed 0 x -5 -> 0. Signed -1 x 1 -> 0xFFFFFFFF_FFFFFFFF.
REQ-035 Handshake: start_i held high continuously -> one accepted op per 36 cycles (N, N+36, ...). Inputs changed during busy -> result unaffected. Start in DONE is ignored.
REQ-036 Reset mid-CALC at edge N+10 -> next cycle IDLE, result_o=0, and no done_o pulse. A new op then completes correctly.
